// File: rtl/s32x_sdr_arb.sv
// s32x_sdr_arb
// Two-port round-robin arbiter that shares the 32X SDRAM between the master
// and slave SH-2 buses. A CS3 bus cycle is captured as a pending request on
// the falling-edge enable. Valid requests are granted one at a time onto the
// SDR_* port. The losing CPU is held in wait, and read data is returned
// through a per-port latch.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   CE_F                  SH bus falling-edge enable (qualifies BS_N capture)
//   M_* / S_*             master / slave SH bus: address, write data, read
//                         data latch, CS3, BS, RD, byte WE strobes, WAIT_N
//   SDR_A/DO/CS/RD/WE     SDRAM transaction outputs, constant during access
//   SDR_DI, SDR_WAIT      SDRAM read data and busy indication
//
// Parameter
//   USE_SDR_WAIT  1: completion waits for SDR_WAIT low; 0: fixed 2-cycle access
module s32x_sdr_arb #(
    parameter bit USE_SDR_WAIT = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_F,
    input  logic [16:0] M_A,
    input  logic [15:0] M_DI,
    output logic [15:0] M_DO,
    input  logic        M_CS_N,
    input  logic        M_BS_N,
    input  logic        M_RD_N,
    input  logic [1:0]  M_WE_N,
    output logic        M_WAIT_N,
    input  logic [16:0] S_A,
    input  logic [15:0] S_DI,
    output logic [15:0] S_DO,
    input  logic        S_CS_N,
    input  logic        S_BS_N,
    input  logic        S_RD_N,
    input  logic [1:0]  S_WE_N,
    output logic        S_WAIT_N,
    output logic [16:0] SDR_A,
    output logic [15:0] SDR_DO,
    input  logic [15:0] SDR_DI,
    output logic        SDR_CS,
    output logic        SDR_RD,
    output logic [1:0]  SDR_WE,
    input  logic        SDR_WAIT
);

    typedef enum logic [1:0] {IDLE, ACC_M, ACC_S} state_t;
    typedef enum logic {SRV_M, SRV_S} srv_t;

    state_t state, state_nxt;
    srv_t   last_srv;

    logic pend_m, pend_s, done_m, done_s;
    logic cnt;      // saturates at 1: only "at least one cycle in ACC" matters
    logic abort;    // granted port dropped CS_N during the access
    logic cap_m, cap_s, req_m, req_s;
    logic grant_m, grant_s, finish, keep, gnt_cs_n;

    assign cap_m = CE_F && !M_CS_N && !M_BS_N;
    assign cap_s = CE_F && !S_CS_N && !S_BS_N;

    // A pending request is only valid once a read or write strobe shows up.
    assign req_m = pend_m && !M_CS_N && (!M_RD_N || (M_WE_N != 2'b11));
    assign req_s = pend_s && !S_CS_N && (!S_RD_N || (S_WE_N != 2'b11));

    // An access whose port let go of CS_N still runs to completion on the
    // SDRAM side, but its result is not delivered to the CPU.
    assign gnt_cs_n = (state == ACC_M) ? M_CS_N : S_CS_N;
    assign keep     = finish && !abort && !gnt_cs_n;

    assign M_WAIT_N = done_m || !(pend_m || (!M_CS_N && !M_BS_N));
    assign S_WAIT_N = done_s || !(pend_s || (!S_CS_N && !S_BS_N));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_nxt = state;
        grant_m   = 1'b0;
        grant_s   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (req_m && (!req_s || last_srv == SRV_S)) begin
                    grant_m   = 1'b1;
                    state_nxt = ACC_M;
                end else if (req_s) begin
                    grant_s   = 1'b1;
                    state_nxt = ACC_S;
                end
            end
            ACC_M, ACC_S: begin
                if (cnt && (!SDR_WAIT || !USE_SDR_WAIT)) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // SDRAM transaction registers, round-robin pointer and access counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SDR_CS   <= 1'b0;
            SDR_RD   <= 1'b0;
            SDR_WE   <= 2'b00;
            SDR_A    <= '0;
            SDR_DO   <= '0;
            cnt      <= 1'b0;
            abort    <= 1'b0;
            last_srv <= SRV_S;
        end else if (grant_m || grant_s) begin
            SDR_CS <= 1'b1;
            SDR_A  <= grant_s ? S_A  : M_A;
            SDR_DO <= grant_s ? S_DI : M_DI;
            // Read wins when both strobes are present.
            SDR_RD <= grant_s ? !S_RD_N : !M_RD_N;
            if (grant_s) SDR_WE <= S_RD_N ? ~S_WE_N : 2'b00;
            else         SDR_WE <= M_RD_N ? ~M_WE_N : 2'b00;
            cnt    <= 1'b0;
            abort  <= 1'b0;
        end else if (finish) begin
            SDR_CS   <= 1'b0;
            SDR_RD   <= 1'b0;
            SDR_WE   <= 2'b00;
            last_srv <= (state == ACC_M) ? SRV_M : SRV_S;
        end else if (state != IDLE) begin
            cnt <= 1'b1;
            if (gnt_cs_n) abort <= 1'b1;
        end
    end

    // Per-port request / completion flags and read data latches.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_m <= 1'b0;
            pend_s <= 1'b0;
            done_m <= 1'b0;
            done_s <= 1'b0;
            M_DO   <= '0;
            S_DO   <= '0;
        end else begin
            if (cap_m)                         pend_m <= 1'b1;
            else if (finish && state == ACC_M) pend_m <= 1'b0;
            else if (M_CS_N && state != ACC_M) pend_m <= 1'b0;

            if (cap_s)                         pend_s <= 1'b1;
            else if (finish && state == ACC_S) pend_s <= 1'b0;
            else if (S_CS_N && state != ACC_S) pend_s <= 1'b0;

            if (cap_m)                       done_m <= 1'b0;
            else if (keep && state == ACC_M) done_m <= 1'b1;
            else if (M_CS_N)                 done_m <= 1'b0;

            if (cap_s)                       done_s <= 1'b0;
            else if (keep && state == ACC_S) done_s <= 1'b1;
            else if (S_CS_N)                 done_s <= 1'b0;

            if (keep && SDR_RD) begin
                if (state == ACC_M) M_DO <= SDR_DI;
                else                S_DO <= SDR_DI;
            end
        end
    end

endmodule

// File: tb/tb_s32x_sdr_arb.sv
// tb_s32x_sdr_arb
// Directed bench for s32x_sdr_arb. A table of per-cycle records is applied.
// Each record holds the inputs for one cycle and the outputs expected before
// the next rising edge. The table is followed by hand-written sequences for
// the CE_F qualifier, a long SDR_WAIT stall and a reset during an access.
module tb_s32x_sdr_arb;

    typedef struct packed {
        logic        cs_n;
        logic        bs_n;
        logic        rd_n;
        logic [1:0]  we_n;
        logic [16:0] a;
        logic [15:0] di;
    } port_in_t;

    typedef struct {
        logic        rst_n;
        port_in_t    m;
        port_in_t    s;
        logic [15:0] sdr_di;
        logic        sdr_wait;
        logic        m_wait_n;
        logic        s_wait_n;
        logic        sdr_cs;
        logic        sdr_rd;
        logic [1:0]  sdr_we;
        logic [16:0] sdr_a;
        logic [15:0] sdr_do;
        logic [15:0] m_do;
        logic [15:0] s_do;
    } row_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CE_F;
    logic [16:0] M_A, S_A;
    logic [15:0] M_DI, S_DI, M_DO, S_DO;
    logic        M_CS_N, M_BS_N, M_RD_N, S_CS_N, S_BS_N, S_RD_N;
    logic [1:0]  M_WE_N, S_WE_N;
    logic        M_WAIT_N, S_WAIT_N;
    logic [16:0] SDR_A;
    logic [15:0] SDR_DO, SDR_DI;
    logic        SDR_CS, SDR_RD, SDR_WAIT;
    logic [1:0]  SDR_WE;

    int checks = 0;
    int errors = 0;
    row_t tbl[$];
    port_in_t idle;

    always #5 CLK = ~CLK;

    s32x_sdr_arb #(.USE_SDR_WAIT(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_F(CE_F),
        .M_A(M_A), .M_DI(M_DI), .M_DO(M_DO), .M_CS_N(M_CS_N), .M_BS_N(M_BS_N),
        .M_RD_N(M_RD_N), .M_WE_N(M_WE_N), .M_WAIT_N(M_WAIT_N),
        .S_A(S_A), .S_DI(S_DI), .S_DO(S_DO), .S_CS_N(S_CS_N), .S_BS_N(S_BS_N),
        .S_RD_N(S_RD_N), .S_WE_N(S_WE_N), .S_WAIT_N(S_WAIT_N),
        .SDR_A(SDR_A), .SDR_DO(SDR_DO), .SDR_DI(SDR_DI), .SDR_CS(SDR_CS),
        .SDR_RD(SDR_RD), .SDR_WE(SDR_WE), .SDR_WAIT(SDR_WAIT)
    );

    function automatic port_in_t pi(logic cs_n, logic bs_n, logic rd_n, logic [1:0] we_n,
                                    logic [16:0] a, logic [15:0] di);
        port_in_t p;
        p.cs_n = cs_n; p.bs_n = bs_n; p.rd_n = rd_n; p.we_n = we_n; p.a = a; p.di = di;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input port_in_t m, input port_in_t s);
        M_CS_N = m.cs_n; M_BS_N = m.bs_n; M_RD_N = m.rd_n; M_WE_N = m.we_n; M_A = m.a; M_DI = m.di;
        S_CS_N = s.cs_n; S_BS_N = s.bs_n; S_RD_N = s.rd_n; S_WE_N = s.we_n; S_A = s.a; S_DI = s.di;
    endtask

    task automatic add(input logic rst_n, input port_in_t m, input port_in_t s,
                       input logic [15:0] di, input logic w,
                       input logic mw, input logic sw, input logic cs, input logic rd,
                       input logic [1:0] we, input logic [16:0] a, input logic [15:0] dout,
                       input logic [15:0] mdo, input logic [15:0] sdo);
        row_t r;
        r.rst_n = rst_n; r.m = m; r.s = s; r.sdr_di = di; r.sdr_wait = w;
        r.m_wait_n = mw; r.s_wait_n = sw; r.sdr_cs = cs; r.sdr_rd = rd; r.sdr_we = we;
        r.sdr_a = a; r.sdr_do = dout; r.m_do = mdo; r.s_do = sdo;
        tbl.push_back(r);
    endtask

    task automatic apply(input int i, input row_t r);
        @(negedge CLK);
        RST_N = r.rst_n;
        drive(r.m, r.s);
        SDR_DI = r.sdr_di;
        SDR_WAIT = r.sdr_wait;
        #1;
        check($sformatf("row%0d M_WAIT_N", i), 32'(M_WAIT_N), 32'(r.m_wait_n));
        check($sformatf("row%0d S_WAIT_N", i), 32'(S_WAIT_N), 32'(r.s_wait_n));
        check($sformatf("row%0d SDR_CS", i),   32'(SDR_CS),   32'(r.sdr_cs));
        check($sformatf("row%0d SDR_RD", i),   32'(SDR_RD),   32'(r.sdr_rd));
        check($sformatf("row%0d SDR_WE", i),   32'(SDR_WE),   32'(r.sdr_we));
        check($sformatf("row%0d SDR_A", i),    32'(SDR_A),    32'(r.sdr_a));
        check($sformatf("row%0d SDR_DO", i),   32'(SDR_DO),   32'(r.sdr_do));
        check($sformatf("row%0d M_DO", i),     32'(M_DO),     32'(r.m_do));
        check($sformatf("row%0d S_DO", i),     32'(S_DO),     32'(r.s_do));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle = pi(1, 1, 1, 2'b11, 17'h0, 16'h0);
        RST_N = 1'b0; CE_F = 1'b1; SDR_DI = '0; SDR_WAIT = 1'b0;
        drive(idle, idle);

        // A: master read 0x00100, SDR_DI=A55A, no wait states
        add(0, idle, idle, 16'hA55A, 0,  1,1, 0,0,2'b00, 17'h000, 16'h0000, 16'h0000, 16'h0000);
        add(1, pi(0,0,0,2'b11,17'h100,0), idle, 16'hA55A, 0,  0,1, 0,0,2'b00, 17'h000, 16'h0000, 16'h0000, 16'h0000);
        add(1, pi(0,1,0,2'b11,17'h100,0), idle, 16'hA55A, 0,  0,1, 0,0,2'b00, 17'h000, 16'h0000, 16'h0000, 16'h0000);
        add(1, pi(0,1,0,2'b11,17'h100,0), idle, 16'hA55A, 0,  0,1, 1,1,2'b00, 17'h100, 16'h0000, 16'h0000, 16'h0000);
        add(1, pi(0,1,0,2'b11,17'h100,0), idle, 16'hA55A, 0,  0,1, 1,1,2'b00, 17'h100, 16'h0000, 16'h0000, 16'h0000);
        add(1, pi(0,1,0,2'b11,17'h100,0), idle, 16'hA55A, 0,  1,1, 0,0,2'b00, 17'h100, 16'h0000, 16'hA55A, 16'h0000);
        add(1, idle, idle, 16'hA55A, 0,  1,1, 0,0,2'b00, 17'h100, 16'h0000, 16'hA55A, 16'h0000);

        // B: reset, then simultaneous M write / S read; M wins the first tie
        add(0, idle, idle, 16'h5AA5, 0,  1,1, 0,0,2'b00, 17'h000, 16'h0000, 16'h0000, 16'h0000);
        add(1, pi(0,0,1,2'b00,17'h200,16'h1234), pi(0,0,0,2'b11,17'h300,0), 16'h5AA5, 0,  0,0, 0,0,2'b00, 17'h000, 16'h0000, 16'h0000, 16'h0000);
        add(1, pi(0,1,1,2'b00,17'h200,16'h1234), pi(0,1,0,2'b11,17'h300,0), 16'h5AA5, 0,  0,0, 0,0,2'b00, 17'h000, 16'h0000, 16'h0000, 16'h0000);
        add(1, pi(0,1,1,2'b00,17'h200,16'h1234), pi(0,1,0,2'b11,17'h300,0), 16'h5AA5, 0,  0,0, 1,0,2'b11, 17'h200, 16'h1234, 16'h0000, 16'h0000);
        add(1, pi(0,1,1,2'b00,17'h200,16'h1234), pi(0,1,0,2'b11,17'h300,0), 16'h5AA5, 0,  0,0, 1,0,2'b11, 17'h200, 16'h1234, 16'h0000, 16'h0000);
        add(1, pi(0,1,1,2'b00,17'h200,16'h1234), pi(0,1,0,2'b11,17'h300,0), 16'h5AA5, 0,  1,0, 0,0,2'b00, 17'h200, 16'h1234, 16'h0000, 16'h0000);
        add(1, idle, pi(0,1,0,2'b11,17'h300,0), 16'h5AA5, 0,  1,0, 1,1,2'b00, 17'h300, 16'h0000, 16'h0000, 16'h0000);
        add(1, idle, pi(0,1,0,2'b11,17'h300,0), 16'h5AA5, 0,  1,0, 1,1,2'b00, 17'h300, 16'h0000, 16'h0000, 16'h0000);
        add(1, idle, pi(0,1,0,2'b11,17'h300,0), 16'h5AA5, 0,  1,1, 0,0,2'b00, 17'h300, 16'h0000, 16'h0000, 16'h5AA5);
        add(1, idle, idle, 16'h5AA5, 0,  1,1, 0,0,2'b00, 17'h300, 16'h0000, 16'h0000, 16'h5AA5);

        // C: M upper-byte write alone, then a tie with M served last: S wins
        add(1, pi(0,0,1,2'b01,17'h010,16'hBEEF), idle, 16'hC33C, 0,  0,1, 0,0,2'b00, 17'h300, 16'h0000, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,1,2'b01,17'h010,16'hBEEF), idle, 16'hC33C, 0,  0,1, 0,0,2'b00, 17'h300, 16'h0000, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,1,2'b01,17'h010,16'hBEEF), idle, 16'hC33C, 0,  0,1, 1,0,2'b10, 17'h010, 16'hBEEF, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,1,2'b01,17'h010,16'hBEEF), idle, 16'hC33C, 0,  0,1, 1,0,2'b10, 17'h010, 16'hBEEF, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,1,2'b01,17'h010,16'hBEEF), idle, 16'hC33C, 0,  1,1, 0,0,2'b00, 17'h010, 16'hBEEF, 16'h0000, 16'h5AA5);
        add(1, idle, idle, 16'hC33C, 0,  1,1, 0,0,2'b00, 17'h010, 16'hBEEF, 16'h0000, 16'h5AA5);
        add(1, pi(0,0,0,2'b11,17'h020,0), pi(0,0,1,2'b10,17'h030,16'h7777), 16'hC33C, 0,  0,0, 0,0,2'b00, 17'h010, 16'hBEEF, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,0,2'b11,17'h020,0), pi(0,1,1,2'b10,17'h030,16'h7777), 16'hC33C, 0,  0,0, 0,0,2'b00, 17'h010, 16'hBEEF, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,0,2'b11,17'h020,0), pi(0,1,1,2'b10,17'h030,16'h7777), 16'hC33C, 0,  0,0, 1,0,2'b01, 17'h030, 16'h7777, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,0,2'b11,17'h020,0), pi(0,1,1,2'b10,17'h030,16'h7777), 16'hC33C, 0,  0,0, 1,0,2'b01, 17'h030, 16'h7777, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,0,2'b11,17'h020,0), pi(0,1,1,2'b10,17'h030,16'h7777), 16'hC33C, 0,  0,1, 0,0,2'b00, 17'h030, 16'h7777, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,0,2'b11,17'h020,0), idle, 16'hC33C, 0,  0,1, 1,1,2'b00, 17'h020, 16'h0000, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,0,2'b11,17'h020,0), idle, 16'hC33C, 0,  0,1, 1,1,2'b00, 17'h020, 16'h0000, 16'h0000, 16'h5AA5);
        add(1, pi(0,1,0,2'b11,17'h020,0), idle, 16'hC33C, 0,  1,1, 0,0,2'b00, 17'h020, 16'h0000, 16'hC33C, 16'h5AA5);
        add(1, idle, idle, 16'hC33C, 0,  1,1, 0,0,2'b00, 17'h020, 16'h0000, 16'hC33C, 16'h5AA5);

        // D: S bus cycle captured, read strobe delayed three cycles
        add(1, idle, pi(0,0,1,2'b11,17'h040,0), 16'h1111, 0,  1,0, 0,0,2'b00, 17'h020, 16'h0000, 16'hC33C, 16'h5AA5);
        add(1, idle, pi(0,1,1,2'b11,17'h040,0), 16'h1111, 0,  1,0, 0,0,2'b00, 17'h020, 16'h0000, 16'hC33C, 16'h5AA5);
        add(1, idle, pi(0,1,1,2'b11,17'h040,0), 16'h1111, 0,  1,0, 0,0,2'b00, 17'h020, 16'h0000, 16'hC33C, 16'h5AA5);
        add(1, idle, pi(0,1,1,2'b11,17'h040,0), 16'h1111, 0,  1,0, 0,0,2'b00, 17'h020, 16'h0000, 16'hC33C, 16'h5AA5);
        add(1, idle, pi(0,1,0,2'b11,17'h040,0), 16'h1111, 0,  1,0, 0,0,2'b00, 17'h020, 16'h0000, 16'hC33C, 16'h5AA5);
        add(1, idle, pi(0,1,0,2'b11,17'h040,0), 16'h1111, 0,  1,0, 1,1,2'b00, 17'h040, 16'h0000, 16'hC33C, 16'h5AA5);
        add(1, idle, pi(0,1,0,2'b11,17'h040,0), 16'h1111, 0,  1,0, 1,1,2'b00, 17'h040, 16'h0000, 16'hC33C, 16'h5AA5);
        add(1, idle, pi(0,1,0,2'b11,17'h040,0), 16'h1111, 0,  1,1, 0,0,2'b00, 17'h040, 16'h0000, 16'hC33C, 16'h1111);
        add(1, idle, idle, 16'h1111, 0,  1,1, 0,0,2'b00, 17'h040, 16'h0000, 16'hC33C, 16'h1111);

        // E: S pends behind M then abandons; M drops CS_N mid-access
        add(1, pi(0,0,0,2'b11,17'h050,0), idle, 16'h9999, 0,  0,1, 0,0,2'b00, 17'h040, 16'h0000, 16'hC33C, 16'h1111);
        add(1, pi(0,1,0,2'b11,17'h050,0), pi(0,0,0,2'b11,17'h060,0), 16'h9999, 0,  0,0, 0,0,2'b00, 17'h040, 16'h0000, 16'hC33C, 16'h1111);
        add(1, pi(0,1,0,2'b11,17'h050,0), pi(0,1,0,2'b11,17'h060,0), 16'h9999, 0,  0,0, 1,1,2'b00, 17'h050, 16'h0000, 16'hC33C, 16'h1111);
        add(1, pi(1,1,1,2'b11,17'h050,0), pi(1,1,1,2'b11,17'h060,0), 16'h9999, 1,  0,0, 1,1,2'b00, 17'h050, 16'h0000, 16'hC33C, 16'h1111);
        add(1, idle, idle, 16'h9999, 0,  0,1, 1,1,2'b00, 17'h050, 16'h0000, 16'hC33C, 16'h1111);
        add(1, idle, idle, 16'h9999, 0,  1,1, 0,0,2'b00, 17'h050, 16'h0000, 16'hC33C, 16'h1111);
        add(1, idle, idle, 16'h9999, 0,  1,1, 0,0,2'b00, 17'h050, 16'h0000, 16'hC33C, 16'h1111);

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // CE_F low: BS_N is not captured, so no request and no grant
        @(negedge CLK);
        CE_F = 1'b0;
        drive(pi(0,0,0,2'b11,17'h0EE,0), idle);
        #1 check("ce_f M_WAIT_N during BS", 32'(M_WAIT_N), 32'd0);
        @(negedge CLK);
        CE_F = 1'b1;
        drive(pi(0,1,0,2'b11,17'h0EE,0), idle);
        #1 check("ce_f M_WAIT_N no pend", 32'(M_WAIT_N), 32'd1);
        @(negedge CLK);
        #1 check("ce_f SDR_CS no grant", 32'(SDR_CS), 32'd0);
        drive(idle, idle);

        // SDR_WAIT held high five cycles during an S read
        @(negedge CLK);
        SDR_WAIT = 1'b1; SDR_DI = 16'hF00F;
        drive(idle, pi(0,0,0,2'b11,17'h0AB,0));
        @(negedge CLK);
        drive(idle, pi(0,1,0,2'b11,17'h0AB,0));
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall%0d SDR_CS", k),   32'(SDR_CS),   32'd1);
            check($sformatf("stall%0d SDR_RD", k),   32'(SDR_RD),   32'd1);
            check($sformatf("stall%0d SDR_A", k),    32'(SDR_A),    32'h0AB);
            check($sformatf("stall%0d S_WAIT_N", k), 32'(S_WAIT_N), 32'd0);
            @(negedge CLK);
        end
        SDR_WAIT = 1'b0;
        #1 check("stall release S_WAIT_N", 32'(S_WAIT_N), 32'd0);
        check("stall release SDR_CS", 32'(SDR_CS), 32'd1);
        @(negedge CLK);
        #1 check("stall done S_DO", 32'(S_DO), 32'hF00F);
        check("stall done SDR_CS", 32'(SDR_CS), 32'd0);
        check("stall done S_WAIT_N", 32'(S_WAIT_N), 32'd1);
        drive(idle, idle);

        // Reset pulsed during ACC_M
        @(negedge CLK);
        SDR_DI = 16'h4242;
        drive(pi(0,0,0,2'b11,17'h0CD,0), idle);
        @(negedge CLK);
        drive(pi(0,1,0,2'b11,17'h0CD,0), idle);
        @(negedge CLK);
        #1 check("rst pre SDR_CS", 32'(SDR_CS), 32'd1);
        RST_N = 1'b0;
        drive(idle, idle);
        #1;
        check("rst SDR_CS", 32'(SDR_CS), 32'd0);
        check("rst SDR_RD", 32'(SDR_RD), 32'd0);
        check("rst SDR_A", 32'(SDR_A), 32'd0);
        check("rst M_WAIT_N", 32'(M_WAIT_N), 32'd1);
        check("rst S_WAIT_N", 32'(S_WAIT_N), 32'd1);
        check("rst S_DO", 32'(S_DO), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            check($sformatf("post_rst%0d SDR_CS", k), 32'(SDR_CS), 32'd0);
            check($sformatf("post_rst%0d M_DO", k), 32'(M_DO), 32'd0);
            check($sformatf("post_rst%0d M_WAIT_N", k), 32'(M_WAIT_N), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
